score_ledger: RTL and testbench
===============================

// Module: score_ledger
// PURPOSE
//  Responder side of the game controller's score_req / valid handshake.
//  Holds a per-player personal-best table and the global high score.
//  On each request it compares the finished game's score against both records, updates them,
//  and returns valid with PersonalBest / GlobalWinner flags.
//  Sits beside the game controller; its outputs drive valid, PersonalBest_in and GlobalWinner_in.
// PARAMETERS
//  ID_W        3   player_id width; table depth is 2**ID_W entries
//  SCORE_W     7   score width
//  MAX_SCORE   99  incoming scores above this are clamped to MAX_SCORE
// PORTS
//  clk             in   1        system clock, rising edge
//  rst             in   1        synchronous, active-high reset
//  score_req       in   1        1-cycle request pulse from the game controller
//  player_id       in   ID_W     player owning the score; sampled with score_req
//  isGuest         in   1        guest game: compare only, never store
//  score           in   SCORE_W  final game score; sampled with score_req
//  clear_all       in   1        1-cycle pulse: zero the table, global score and global id
//  valid           out  1        1-cycle response pulse
//  PersonalBest    out  1        score beat the player's stored best; held until the next valid
//  GlobalWinner    out  1        score beat the global best; held until the next valid
//  best_score      out  SCORE_W  player's best after the update
//  global_score    out  SCORE_W  global best after the update
//  global_id       out  ID_W     holder of the global best
//  busy            out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; all outputs 0; table, global score and global id zeroed.
//  rst mid-transaction aborts it: no table write, no valid.
//  FSM: IDLE -> LOAD -> UPDATE -> RESP -> IDLE.
//   IDLE: score_req=1 latches player_id, isGuest and clamp(score); go to LOAD.
//   LOAD: register table[id] and the global best.
//   UPDATE:
//    pb = !isGuest && (s > table[id]);  gw = !isGuest && (s > global).
//    If pb, write table[id]=s. If gw, global=s and global_id=id.
//    Compares are unsigned and strict: a tie is not a win, and the existing holder keeps the title.
//   RESP: valid=1 for exactly this cycle. PersonalBest, GlobalWinner, best_score,
//    global_score and global_id are registered here and held until the next RESP.
//  Latency: score_req sampled at edge N -> valid high in the cycle after edge N+3.
//   Request-to-request throughput is 4 cycles.
//  score_req while busy=1 is ignored (dropped, no queueing). The requester waits for valid.
//  Guest: table and global are untouched; both flags are 0.
//   best_score=0 and global_score/global_id report the current records; valid is still pulsed.
//  clear_all in IDLE: zeroes all records at that edge. A score_req in the same cycle
//   starts its transaction against the cleared records.
//  clear_all while busy: deferred; executed on the first IDLE cycle, before any new request.
//  Clamp: score > MAX_SCORE is treated as MAX_SCORE for both compare and store.
//  Fresh table entry = 0, so a first game with score 0 is not a personal best.
// TESTING
//  1 reset, then req id=2 score=40 -> valid exactly 4 edges later; PB=1 GW=1 best=40 global=40 gid=2.
//  2 then req id=5 score=40 -> PB=1 GW=0 (tie); global stays 40, gid=2; best=40.
//  3 req id=2 score=30 -> PB=0 GW=0 best=40; a second req issued 1 cycle later is dropped
//    (only one valid pulse).
//  4 guest req id=3 score=99 -> PB=0 GW=0 best=0 global=40; the following id=3 score=1 -> PB=1.
//  5 req id=1 score=120 -> clamped; best=99 global=99 gid=1 PB=1 GW=1.
//  6 rst during UPDATE -> no valid; table all zero; clear_all while busy -> records zero after RESP.

Source files
------------

// File: rtl/score_ledger.sv
// Per-player personal-best table plus global high score, answering score_req with valid and win flags.
// Latency: score_req sampled at edge N -> valid high after edge N+3; requests arriving while busy are dropped.
module score_ledger #(
    parameter int ID_W      = 3,
    parameter int SCORE_W   = 7,
    parameter int MAX_SCORE = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_req,
    input  logic [ID_W-1:0]    player_id,
    input  logic               isGuest,
    input  logic [SCORE_W-1:0] score,
    input  logic               clear_all,
    output logic               valid,
    output logic               PersonalBest,
    output logic               GlobalWinner,
    output logic [SCORE_W-1:0] best_score,
    output logic [SCORE_W-1:0] global_score,
    output logic [ID_W-1:0]    global_id,
    output logic               busy
);
    localparam int DEPTH = 1 << ID_W;
    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, LOAD, UPDATE, RESP} state_t;

    state_t             state_q;
    logic [SCORE_W-1:0] tbl_q [DEPTH];
    logic [SCORE_W-1:0] glob_q, cur_best_q, cur_glob_q, s_q, res_best_q;
    logic [ID_W-1:0]    gid_q, id_q;
    logic               guest_q, pb_q, gw_q, clr_pend_q;
    logic               valid_q, pb_out_q, gw_out_q;
    logic [SCORE_W-1:0] best_out_q, gscore_out_q;
    logic [ID_W-1:0]    gid_out_q;

    logic [SCORE_W-1:0] s_d;
    logic               pb_d, gw_d;

    always_comb begin
        s_d  = (score > MAX_S) ? MAX_S : score;
        pb_d = !guest_q && (s_q > cur_best_q);
        gw_d = !guest_q && (s_q > cur_glob_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            glob_q       <= '0;
            gid_q        <= '0;
            cur_best_q   <= '0;
            cur_glob_q   <= '0;
            s_q          <= '0;
            id_q         <= '0;
            guest_q      <= 1'b0;
            pb_q         <= 1'b0;
            gw_q         <= 1'b0;
            res_best_q   <= '0;
            clr_pend_q   <= 1'b0;
            valid_q      <= 1'b0;
            pb_out_q     <= 1'b0;
            gw_out_q     <= 1'b0;
            best_out_q   <= '0;
            gscore_out_q <= '0;
            gid_out_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            // A clear arriving mid-transaction waits for the next IDLE cycle.
            if (clear_all && state_q != IDLE) clr_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (clear_all || clr_pend_q) begin
                        for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
                        glob_q     <= '0;
                        gid_q      <= '0;
                        clr_pend_q <= 1'b0;
                    end
                    if (score_req) begin
                        id_q    <= player_id;
                        guest_q <= isGuest;
                        s_q     <= s_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    cur_best_q <= tbl_q[id_q];
                    cur_glob_q <= glob_q;
                    state_q    <= UPDATE;
                end
                UPDATE: begin
                    pb_q       <= pb_d;
                    gw_q       <= gw_d;
                    res_best_q <= guest_q ? '0 : (pb_d ? s_q : cur_best_q);
                    if (pb_d) tbl_q[id_q] <= s_q;
                    if (gw_d) begin
                        glob_q <= s_q;
                        gid_q  <= id_q;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    valid_q      <= 1'b1;
                    pb_out_q     <= pb_q;
                    gw_out_q     <= gw_q;
                    best_out_q   <= res_best_q;
                    gscore_out_q <= glob_q;
                    gid_out_q    <= gid_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid        = valid_q;
    assign PersonalBest = pb_out_q;
    assign GlobalWinner = gw_out_q;
    assign best_score   = best_out_q;
    assign global_score = gscore_out_q;
    assign global_id    = gid_out_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_score_ledger.sv
// Directed vector bench for score_ledger: table of requests with hand-computed responses plus reset/clear sequences.
module tb_score_ledger;
    logic       clk = 1'b0;
    logic       rst, score_req, isGuest, clear_all;
    logic [2:0] player_id;
    logic [6:0] score;
    logic       valid, PersonalBest, GlobalWinner, busy;
    logic [6:0] best_score, global_score;
    logic [2:0] global_id;

    int checks = 0;
    int failures = 0;

    score_ledger dut (
        .clk(clk), .rst(rst), .score_req(score_req), .player_id(player_id),
        .isGuest(isGuest), .score(score), .clear_all(clear_all), .valid(valid),
        .PersonalBest(PersonalBest), .GlobalWinner(GlobalWinner),
        .best_score(best_score), .global_score(global_score),
        .global_id(global_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] id;
        logic       guest;
        logic [6:0] score;
        logic       dup;
        int         clr_at;
        logic       pb;
        logic       gw;
        logic [6:0] best;
        logic [6:0] gs;
        logic [2:0] gid;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        int lat;
        int nvld;
        player_id = v.id;
        isGuest   = v.guest;
        score     = v.score;
        score_req = 1'b1;
        clear_all = (v.clr_at == 0);
        tick;
        lat = 1;
        score_req = v.dup;
        clear_all = (v.clr_at == 1);
        while (!valid && lat < 10) begin
            tick;
            lat++;
            score_req = 1'b0;
            clear_all = (v.clr_at == lat);
        end
        score_req = 1'b0;
        clear_all = 1'b0;
        chk("latency", lat, 4);
        chk("valid", int'(valid), 1);
        chk("PersonalBest", int'(PersonalBest), int'(v.pb));
        chk("GlobalWinner", int'(GlobalWinner), int'(v.gw));
        chk("best_score", int'(best_score), int'(v.best));
        chk("global_score", int'(global_score), int'(v.gs));
        chk("global_id", int'(global_id), int'(v.gid));
        nvld = 0;
        repeat (6) begin
            tick;
            if (valid) nvld++;
        end
        chk("extra_valid", nvld, 0);
        chk("held_PersonalBest", int'(PersonalBest), int'(v.pb));
        chk("idle_busy", int'(busy), 0);
    endtask

    vec_t vecs[8];
    vec_t v;
    int   nvld;

    initial begin
        //         id guest score dup clr  pb gw best gs  gid
        vecs[0] = '{3'd2, 1'b0, 7'd40,  1'b0, -1, 1'b1, 1'b1, 7'd40, 7'd40, 3'd2};
        vecs[1] = '{3'd5, 1'b0, 7'd40,  1'b0, -1, 1'b1, 1'b0, 7'd40, 7'd40, 3'd2};
        vecs[2] = '{3'd2, 1'b0, 7'd30,  1'b1, -1, 1'b0, 1'b0, 7'd40, 7'd40, 3'd2};
        vecs[3] = '{3'd3, 1'b1, 7'd99,  1'b0, -1, 1'b0, 1'b0, 7'd0,  7'd40, 3'd2};
        vecs[4] = '{3'd3, 1'b0, 7'd1,   1'b0, -1, 1'b1, 1'b0, 7'd1,  7'd40, 3'd2};
        vecs[5] = '{3'd1, 1'b0, 7'd120, 1'b0, -1, 1'b1, 1'b1, 7'd99, 7'd99, 3'd1};
        vecs[6] = '{3'd1, 1'b0, 7'd99,  1'b0, -1, 1'b0, 1'b0, 7'd99, 7'd99, 3'd1};
        vecs[7] = '{3'd0, 1'b0, 7'd0,   1'b0, -1, 1'b0, 1'b0, 7'd0,  7'd99, 3'd1};

        rst = 1'b1; score_req = 1'b0; isGuest = 1'b0; clear_all = 1'b0;
        player_id = '0; score = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_flags", int'({PersonalBest, GlobalWinner}), 0);
        chk("reset_scores", int'({best_score, global_score, global_id}), 0);

        for (int i = 0; i < 8; i++) do_req(vecs[i]);

        // Reset while the FSM is in UPDATE aborts the transaction.
        player_id = 3'd6; isGuest = 1'b0; score = 7'd50; score_req = 1'b1;
        tick;
        score_req = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        nvld = 0;
        repeat (6) begin
            tick;
            if (valid) nvld++;
        end
        chk("rst_abort_valid", nvld, 0);
        chk("rst_abort_busy", int'(busy), 0);
        chk("rst_abort_gscore", int'(global_score), 0);

        // Table must be empty after reset: id5 held 40 before, id6 never stored.
        v = '{3'd2, 1'b0, 7'd0, 1'b0, -1, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0};
        do_req(v);
        v = '{3'd5, 1'b0, 7'd1, 1'b0, -1, 1'b1, 1'b1, 7'd1, 7'd1, 3'd5};
        do_req(v);
        v = '{3'd6, 1'b0, 7'd1, 1'b0, -1, 1'b1, 1'b0, 7'd1, 7'd1, 3'd5};
        do_req(v);

        // Clear during LOAD: this response still sees old records, next one sees cleared.
        v = '{3'd4, 1'b0, 7'd10, 1'b0, 1, 1'b1, 1'b1, 7'd10, 7'd10, 3'd4};
        do_req(v);
        v = '{3'd4, 1'b0, 7'd3, 1'b0, -1, 1'b1, 1'b1, 7'd3, 7'd3, 3'd4};
        do_req(v);
        v = '{3'd5, 1'b0, 7'd1, 1'b0, -1, 1'b1, 1'b0, 7'd1, 7'd3, 3'd4};
        do_req(v);

        // Clear in IDLE together with a request: request runs against cleared records.
        v = '{3'd2, 1'b0, 7'd2, 1'b0, 0, 1'b1, 1'b1, 7'd2, 7'd2, 3'd2};
        do_req(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
